// File: rtl/frv_wb_arbiter.sv
// frv_wb_arbiter: two-master (imem, dmem) to one-slave Wishbone classic arbiter.
// The instruction and data ports of the core share one memory bus, with a single
// transaction outstanding at a time. The grant is held until the slave acks or the
// granted master drops cyc.
// Ties go round-robin, or always to dmem when FIXED_PRIO = 1.
// Optional feature: define FRV_ARB_TIMEOUT_EN to add an ack watchdog. When it fires,
// the granted master gets ack with data 32'hDEADBEEF and timeout_o pulses for one cycle.
module frv_wb_arbiter #(
  parameter int ADR_W       = 32,
  parameter bit FIXED_PRIO  = 1'b0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_imem_cyc_i,
  input  logic             wb_imem_stb_i,
  input  logic [ADR_W-1:0] wb_imem_adr_i,
  output logic [31:0]      wb_imem_dat_o,
  output logic             wb_imem_ack_o,
  input  logic             wb_dmem_cyc_i,
  input  logic             wb_dmem_stb_i,
  input  logic             wb_dmem_we_i,
  input  logic [3:0]       wb_dmem_be_i,
  input  logic [ADR_W-1:0] wb_dmem_adr_i,
  input  logic [31:0]      wb_dmem_dat_i,
  output logic [31:0]      wb_dmem_dat_o,
  output logic             wb_dmem_ack_o,
  output logic             wb_mem_cyc_o,
  output logic             wb_mem_stb_o,
  output logic             wb_mem_we_o,
  output logic [3:0]       wb_mem_sel_o,
  output logic [ADR_W-1:0] wb_mem_adr_o,
  output logic [31:0]      wb_mem_dat_o,
  input  logic [31:0]      wb_mem_dat_i,
  input  logic             wb_mem_ack_i,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic {MST_I, MST_D} mst_t;

  state_t state_q, state_d;
  mst_t   last_q, last_d;
  logic   req_i, req_d;
  logic   expire;

  assign req_i = wb_imem_cyc_i & wb_imem_stb_i;
  assign req_d = wb_dmem_cyc_i & wb_dmem_stb_i;

`ifdef FRV_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] wait_q;

  // The watchdog fires on the last allowed grant cycle if the slave still has not acked.
  assign expire = (state_q != IDLE) && !wb_mem_ack_i &&
                  (wait_q == CNT_W'(TIMEOUT_CYC - 1));

  // Wait counter: held at zero while idle, so each grant starts counting from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else if (state_q == IDLE) begin
      wait_q <= '0;
    end else if (!wb_mem_ack_i) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign timeout_o = expire;

  // State register and the last-granted master, which is used for round-robin ties.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= MST_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state, and live routing of the bus and ack for the granted master.
  always_comb begin
    // NOTE: every output gets a default here first; a path that forgets one would infer a latch.
    state_d       = state_q;
    last_d        = last_q;
    wb_mem_cyc_o  = 1'b0;
    wb_mem_stb_o  = 1'b0;
    wb_mem_we_o   = 1'b0;
    wb_mem_sel_o  = 4'h0;
    wb_mem_adr_o  = '0;
    wb_mem_dat_o  = 32'h0;
    wb_imem_ack_o = 1'b0;
    wb_dmem_ack_o = 1'b0;
    wb_imem_dat_o = wb_mem_dat_i;
    wb_dmem_dat_o = wb_mem_dat_i;

    case (state_q)
      IDLE: begin
        if (req_d && (!req_i || FIXED_PRIO || last_q == MST_I)) begin
          state_d = GNT_D;
          last_d  = MST_D;
        end else if (req_i) begin
          state_d = GNT_I;
          last_d  = MST_I;
        end
      end
      GNT_I: begin
        wb_mem_cyc_o  = wb_imem_cyc_i & ~expire;
        wb_mem_stb_o  = wb_imem_cyc_i & wb_imem_stb_i & ~expire;
        wb_mem_sel_o  = 4'hF;
        wb_mem_adr_o  = wb_imem_adr_i;
        wb_imem_ack_o = wb_mem_ack_i | expire;
        if (expire) wb_imem_dat_o = 32'hDEADBEEF;
        if (wb_mem_ack_i || expire || !wb_imem_cyc_i) state_d = IDLE;
      end
      GNT_D: begin
        wb_mem_cyc_o  = wb_dmem_cyc_i & ~expire;
        wb_mem_stb_o  = wb_dmem_cyc_i & wb_dmem_stb_i & ~expire;
        wb_mem_we_o   = wb_dmem_we_i;
        wb_mem_sel_o  = wb_dmem_be_i;
        wb_mem_adr_o  = wb_dmem_adr_i;
        wb_mem_dat_o  = wb_dmem_dat_i;
        wb_dmem_ack_o = wb_mem_ack_i | expire;
        if (expire) wb_dmem_dat_o = 32'hDEADBEEF;
        if (wb_mem_ack_i || expire || !wb_dmem_cyc_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frv_wb_arbiter.sv
// tb_frv_wb_arbiter: randomized bench for frv_wb_arbiter.
// Instance 0 uses round-robin ties and instance 1 uses fixed dmem priority.
// Each instance has its own random masters and its own random slave.
// A bus-ownership model predicts every output on every cycle.
// If FRV_ARB_TIMEOUT_EN is defined, the watchdog (TIMEOUT_CYC = 8) is modelled too.
module tb_frv_wb_arbiter;

  localparam int ADR_W = 32;
  localparam int TCYC  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_cyc [2];
  logic        imem_stb [2];
  logic [31:0] imem_adr [2];
  logic [31:0] imem_rdat[2];
  logic        imem_ack [2];
  logic        dmem_cyc [2];
  logic        dmem_stb [2];
  logic        dmem_we  [2];
  logic [3:0]  dmem_be  [2];
  logic [31:0] dmem_adr [2];
  logic [31:0] dmem_wdat[2];
  logic [31:0] dmem_rdat[2];
  logic        dmem_ack [2];
  logic        mem_cyc  [2];
  logic        mem_stb  [2];
  logic        mem_we   [2];
  logic [3:0]  mem_sel  [2];
  logic [31:0] mem_adr  [2];
  logic [31:0] mem_wdat [2];
  logic [31:0] mem_rdat [2];
  logic        mem_ack  [2];
  logic        tmo      [2];

  frv_wb_arbiter #(.ADR_W(ADR_W), .FIXED_PRIO(1'b0), .TIMEOUT_CYC(TCYC)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .wb_imem_cyc_i(imem_cyc[0]), .wb_imem_stb_i(imem_stb[0]), .wb_imem_adr_i(imem_adr[0]),
    .wb_imem_dat_o(imem_rdat[0]), .wb_imem_ack_o(imem_ack[0]),
    .wb_dmem_cyc_i(dmem_cyc[0]), .wb_dmem_stb_i(dmem_stb[0]), .wb_dmem_we_i(dmem_we[0]),
    .wb_dmem_be_i(dmem_be[0]), .wb_dmem_adr_i(dmem_adr[0]), .wb_dmem_dat_i(dmem_wdat[0]),
    .wb_dmem_dat_o(dmem_rdat[0]), .wb_dmem_ack_o(dmem_ack[0]),
    .wb_mem_cyc_o(mem_cyc[0]), .wb_mem_stb_o(mem_stb[0]), .wb_mem_we_o(mem_we[0]),
    .wb_mem_sel_o(mem_sel[0]), .wb_mem_adr_o(mem_adr[0]), .wb_mem_dat_o(mem_wdat[0]),
    .wb_mem_dat_i(mem_rdat[0]), .wb_mem_ack_i(mem_ack[0]), .timeout_o(tmo[0])
  );

  frv_wb_arbiter #(.ADR_W(ADR_W), .FIXED_PRIO(1'b1), .TIMEOUT_CYC(TCYC)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .wb_imem_cyc_i(imem_cyc[1]), .wb_imem_stb_i(imem_stb[1]), .wb_imem_adr_i(imem_adr[1]),
    .wb_imem_dat_o(imem_rdat[1]), .wb_imem_ack_o(imem_ack[1]),
    .wb_dmem_cyc_i(dmem_cyc[1]), .wb_dmem_stb_i(dmem_stb[1]), .wb_dmem_we_i(dmem_we[1]),
    .wb_dmem_be_i(dmem_be[1]), .wb_dmem_adr_i(dmem_adr[1]), .wb_dmem_dat_i(dmem_wdat[1]),
    .wb_dmem_dat_o(dmem_rdat[1]), .wb_dmem_ack_o(dmem_ack[1]),
    .wb_mem_cyc_o(mem_cyc[1]), .wb_mem_stb_o(mem_stb[1]), .wb_mem_we_o(mem_we[1]),
    .wb_mem_sel_o(mem_sel[1]), .wb_mem_adr_o(mem_adr[1]), .wb_mem_dat_o(mem_wdat[1]),
    .wb_mem_dat_i(mem_rdat[1]), .wb_mem_ack_i(mem_ack[1]), .timeout_o(tmo[1])
  );

  // Ownership model: owner 0 = nobody, 1 = imem, 2 = dmem.
  // last_win is the master that won the most recent grant.
  int owner    [2];
  int last_win [2];
  int waited   [2];
  bit pend_i   [2];
  bit pend_d   [2];
  int mode;          // 0 random traffic, 1 both masters always busy, 2 silent slave
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k]    = 0;
      last_win[k] = 1;
      waited[k]   = 0;
    end
  endtask

  // Predict every output of instance k from the current owner and inputs,
  // compare the DUT against the prediction, then advance ownership by one clock.
  task automatic check_and_step(input int k);
    logic        e_cyc, e_stb, e_we, e_ia, e_da, e_to, ack_in, expire, ri, rd, winner_d;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_wd, e_id, e_dd;
    ack_in = mem_ack[k];
    expire = 1'b0;
`ifdef FRV_ARB_TIMEOUT_EN
    expire = (owner[k] != 0) && (waited[k] == TCYC - 1) && !ack_in;
`endif
    {e_cyc, e_stb, e_we, e_ia, e_da} = '0;
    e_sel = 4'h0; e_adr = '0; e_wd = '0;
    e_id  = mem_rdat[k]; e_dd = mem_rdat[k];
    e_to  = expire;
    if (owner[k] == 1) begin
      e_cyc = imem_cyc[k] && !expire;
      e_stb = imem_cyc[k] && imem_stb[k] && !expire;
      e_sel = 4'hF;
      e_adr = imem_adr[k];
      e_ia  = ack_in || expire;
      if (expire) e_id = 32'hDEADBEEF;
    end else if (owner[k] == 2) begin
      e_cyc = dmem_cyc[k] && !expire;
      e_stb = dmem_cyc[k] && dmem_stb[k] && !expire;
      e_we  = dmem_we[k];
      e_sel = dmem_be[k];
      e_adr = dmem_adr[k];
      e_wd  = dmem_wdat[k];
      e_da  = ack_in || expire;
      if (expire) e_dd = 32'hDEADBEEF;
    end
    check($sformatf("bus%0d", k),
          {mem_cyc[k], mem_stb[k], mem_we[k], mem_sel[k], mem_adr[k], mem_wdat[k]},
          {e_cyc, e_stb, e_we, e_sel, e_adr, e_wd});
    check($sformatf("acks%0d", k), {imem_ack[k], dmem_ack[k]}, {e_ia, e_da});
    check($sformatf("imem_dat%0d", k), imem_rdat[k], e_id);
    check($sformatf("dmem_dat%0d", k), dmem_rdat[k], e_dd);
    check($sformatf("timeout%0d", k), tmo[k], e_to);

    // Masters retire a transaction when they see its ack.
    if (e_ia) pend_i[k] = 1'b0;
    if (e_da) pend_d[k] = 1'b0;

    // Advance ownership: release on ack, watchdog or abort; otherwise arbitrate.
    if (owner[k] != 0) begin
      if (ack_in || expire || !(owner[k] == 1 ? imem_cyc[k] : dmem_cyc[k])) owner[k] = 0;
      else waited[k]++;
    end else begin
      ri = imem_cyc[k] && imem_stb[k];
      rd = dmem_cyc[k] && dmem_stb[k];
      if (ri || rd) begin
        if (ri && rd) winner_d = (k == 1) || (last_win[k] == 1);
        else          winner_d = rd;
        owner[k]    = winner_d ? 2 : 1;
        last_win[k] = owner[k];
        waited[k]   = 0;
      end
    end
  endtask

  task automatic drive(input int k);
    if (mode == 0 && pend_i[k] && ($urandom % 16) == 0) pend_i[k] = 1'b0;
    if (mode == 0 && pend_d[k] && ($urandom % 16) == 0) pend_d[k] = 1'b0;
    if (!pend_i[k]) begin
      imem_adr[k] = $urandom;
      if (mode != 0 || ($urandom % 2) == 0) pend_i[k] = 1'b1;
    end
    if (!pend_d[k]) begin
      dmem_adr[k]  = $urandom;
      dmem_wdat[k] = $urandom;
      dmem_be[k]   = 4'($urandom);
      dmem_we[k]   = ($urandom % 2) == 0;
      if (mode != 0 || ($urandom % 2) == 0) pend_d[k] = 1'b1;
    end
    imem_cyc[k] = pend_i[k];
    imem_stb[k] = pend_i[k] || (($urandom % 2) == 0);
    dmem_cyc[k] = pend_d[k];
    dmem_stb[k] = pend_d[k] || (($urandom % 2) == 0);
    mem_rdat[k] = $urandom;
    case (mode)
      0:       mem_ack[k] = ($urandom % 3) == 0;
      1:       mem_ack[k] = ($urandom % 2) == 0;
      default: mem_ack[k] = 1'b0;
    endcase
  endtask

  task automatic run_cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_and_step(k);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    for (int k = 0; k < 2; k++) drive(k);
  endtask

  initial begin
    mode = 0;
    for (int k = 0; k < 2; k++) begin
      pend_i[k] = 1'b0;
      pend_d[k] = 1'b0;
      drive(k);
    end
    model_reset();

    // Reset state, checked with live requests and acks present on the inputs.
    repeat (3) run_cycle();
    rst = 1'b0;

    repeat (1500) run_cycle();

    mode = 1;
    repeat (200) run_cycle();

    // Asynchronous reset while dmem holds the grant on the round-robin instance.
    for (int i = 0; i < 50 && owner[0] != 2; i++) run_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {mem_cyc[0], mem_stb[0], dmem_ack[0], imem_ack[0]}, 4'b0000);
    model_reset();
    run_cycle();
    rst = 1'b0;
    repeat (100) run_cycle();

    mode = 2;
    repeat (40) run_cycle();

    mode = 0;
    repeat (300) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
